ctrl_mem_load: RTL and testbench

- Upstream stage of the convolution datapath.
- Accepts input vector x and filter f over two independent AXI-stream-style slave interfaces and writes them into the x and f memories.
- Once both memories are full, asserts conv_start and hands address control to the convolution output controller.
- Owns the x/f address counters, which serve as write addresses during load and read addresses during convolution. Returns to load on conv_done.

---
 rtl/ctrl_mem_load.sv | 125 ++++++++++++
 tb/tb_ctrl_mem_load.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mem_load.sv
// Load controller for the convolution datapath: streams x and f samples into their
// memories, then hands the shared address counters to the convolution controller.
module ctrl_mem_load #(
  parameter int DATA_WIDTH       = 8,
  parameter int X_MEM_SIZE       = 8,
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       s_data_in_x,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic [DATA_WIDTH-1:0]       s_data_in_f,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  input  logic                        load_xaddr,
  input  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
  input  logic                        en_xaddr_incr,
  input  logic                        en_faddr_incr,
  input  logic                        conv_done,
  output logic                        x_wr_en,
  output logic [DATA_WIDTH-1:0]       x_wr_data,
  output logic [X_MEM_ADDR_WIDTH-1:0] x_addr,
  output logic                        f_wr_en,
  output logic [DATA_WIDTH-1:0]       f_wr_data,
  output logic [F_MEM_ADDR_WIDTH-1:0] f_addr,
  output logic                        conv_start
);

  typedef enum logic {
    LOAD = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
  localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

  state_t                        state_q, state_d;
  logic [X_MEM_ADDR_WIDTH-1:0]   x_addr_q, x_addr_d;
  logic [F_MEM_ADDR_WIDTH-1:0]   f_addr_q, f_addr_d;
  logic                          x_full_q, x_full_d;
  logic                          f_full_q, f_full_d;
  logic                          x_hs, f_hs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= LOAD;
      x_addr_q <= '0;
      f_addr_q <= '0;
      x_full_q <= 1'b0;
      f_full_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_addr_q <= x_addr_d;
      f_addr_q <= f_addr_d;
      x_full_q <= x_full_d;
      f_full_q <= f_full_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_addr_d  = x_addr_q;
    f_addr_d  = f_addr_q;
    x_full_d  = x_full_q;
    f_full_d  = f_full_q;
    s_ready_x = 1'b0;
    s_ready_f = 1'b0;
    x_hs      = 1'b0;
    f_hs      = 1'b0;

    case (state_q)
      LOAD: begin
        s_ready_x = !x_full_q;
        s_ready_f = !f_full_q;
        x_hs      = s_valid_x && !x_full_q;
        f_hs      = s_valid_f && !f_full_q;
        // Wrap at SIZE-1 so non-power-of-two memories hand over starting at 0.
        if (x_hs) begin
          if (x_addr_q == X_LAST) begin
            x_full_d = 1'b1;
            x_addr_d = '0;
          end else begin
            x_addr_d = x_addr_q + 1'b1;
          end
        end
        if (f_hs) begin
          if (f_addr_q == F_LAST) begin
            f_full_d = 1'b1;
            f_addr_d = '0;
          end else begin
            f_addr_d = f_addr_q + 1'b1;
          end
        end
        if (x_full_q && f_full_q) state_d = CONV;
      end
      CONV: begin
        if (conv_done) begin
          state_d  = LOAD;
          x_addr_d = '0;
          f_addr_d = '0;
          x_full_d = 1'b0;
          f_full_d = 1'b0;
        end else if (load_xaddr) begin
          x_addr_d = load_xaddr_val;
          f_addr_d = '0;
        end else begin
          if (en_xaddr_incr && (x_addr_q != X_LAST)) x_addr_d = x_addr_q + 1'b1;
          if (en_faddr_incr) f_addr_d = (f_addr_q == F_LAST) ? '0 : f_addr_q + 1'b1;
        end
      end
    endcase
  end

  assign x_wr_en    = x_hs;
  assign f_wr_en    = f_hs;
  assign x_wr_data  = s_data_in_x;
  assign f_wr_data  = s_data_in_f;
  assign x_addr     = x_addr_q;
  assign f_addr     = f_addr_q;
  assign conv_start = (state_q == CONV);

endmodule

// File: tb/tb_ctrl_mem_load.sv
// Directed bench for ctrl_mem_load: vector table for streaming and CONV addressing,
// plus sequences for gapped loading and mid-load reset.
module tb_ctrl_mem_load;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data_in_x = '0, s_data_in_f = '0;
  logic       s_valid_x = 1'b0, s_valid_f = 1'b0;
  logic       s_ready_x, s_ready_f;
  logic       load_xaddr = 1'b0;
  logic [2:0] load_xaddr_val = '0;
  logic       en_xaddr_incr = 1'b0, en_faddr_incr = 1'b0, conv_done = 1'b0;
  logic       x_wr_en, f_wr_en, conv_start;
  logic [7:0] x_wr_data, f_wr_data;
  logic [2:0] x_addr;
  logic [1:0] f_addr;

  ctrl_mem_load #(
    .DATA_WIDTH(8), .X_MEM_SIZE(8), .F_MEM_SIZE(4),
    .X_MEM_ADDR_WIDTH(3), .F_MEM_ADDR_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .load_xaddr(load_xaddr), .load_xaddr_val(load_xaddr_val),
    .en_xaddr_incr(en_xaddr_incr), .en_faddr_incr(en_faddr_incr),
    .conv_done(conv_done),
    .x_wr_en(x_wr_en), .x_wr_data(x_wr_data), .x_addr(x_addr),
    .f_wr_en(f_wr_en), .f_wr_data(f_wr_data), .f_addr(f_addr),
    .conv_start(conv_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vx; logic [7:0] dx; logic vf; logic [7:0] df;
    logic       ld; logic [2:0] lv; logic ix; logic ifa; logic dn;
    logic       rx, rf, wx, wf; logic [2:0] xa; logic [1:0] fa; logic cs;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_xw = 0;

  // Reference model for the sequence tests
  logic m_conv, m_xf, m_ff;
  int   m_xa, m_fa, m_xcnt, m_fcnt;

  function automatic vec_t mk(logic vx, logic [7:0] dx, logic vf, logic [7:0] df,
                              logic ld, logic [2:0] lv, logic ix, logic ifa, logic dn,
                              logic rx, logic rf, logic wx, logic wf,
                              logic [2:0] xa, logic [1:0] fa, logic cs);
    vec_t v;
    v.vx = vx; v.dx = dx; v.vf = vf; v.df = df;
    v.ld = ld; v.lv = lv; v.ix = ix; v.ifa = ifa; v.dn = dn;
    v.rx = rx; v.rf = rf; v.wx = wx; v.wf = wf; v.xa = xa; v.fa = fa; v.cs = cs;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_conv = 1'b0; m_xf = 1'b0; m_ff = 1'b0;
    m_xa = 0; m_fa = 0; m_xcnt = 0; m_fcnt = 0;
  endtask

  // One cycle against the model: drive on negedge, compare, update after posedge.
  task automatic cyc(input logic rst, input logic vx, input logic [7:0] dx,
                     input logic vf, input logic [7:0] df, input logic dn);
    logic ex_rx, ex_rf, ex_wx, ex_wf, go;
    @(negedge clk);
    reset = rst; s_valid_x = vx; s_data_in_x = dx; s_valid_f = vf; s_data_in_f = df;
    conv_done = dn; load_xaddr = 1'b0; en_xaddr_incr = 1'b0; en_faddr_incr = 1'b0;
    #1;
    ex_rx = !m_conv && !m_xf;
    ex_rf = !m_conv && !m_ff;
    ex_wx = vx && ex_rx;
    ex_wf = vf && ex_rf;
    if (rst) begin
      chk("seq s_ready_x", s_ready_x, ex_rx);
      chk("seq s_ready_f", s_ready_f, ex_rf);
      chk("seq x_wr_en", x_wr_en, ex_wx);
      chk("seq f_wr_en", f_wr_en, ex_wf);
      chk("seq x_addr", x_addr, m_xa);
      chk("seq f_addr", f_addr, m_fa);
      chk("seq conv_start", conv_start, m_conv);
      if (x_wr_en === 1'b1) n_xw++;
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (m_conv) begin
      if (dn) model_reset();
    end else begin
      go = m_xf && m_ff;
      if (ex_wx) begin
        m_xcnt++;
        if (m_xa == 7) begin m_xf = 1'b1; m_xa = 0; end else m_xa++;
      end
      if (ex_wf) begin
        m_fcnt++;
        if (m_fa == 3) begin m_ff = 1'b1; m_fa = 0; end else m_fa++;
      end
      if (go) m_conv = 1'b1;
    end
  endtask

  initial begin
    int c, xdone;
    logic vx, vf;

    model_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // reset state
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // streaming load, then CONV address control
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 8'(k+1), 1, 8'(k+1), 0,0,0,0,0, 1,1,1,1, 3'(k), 2'(k), 0));
    for (int k = 4; k < 8; k++)
      tbl.push_back(mk(1, 8'(k+1), 1, 8'hEE,   0,0,0,0,0, 1,0,1,0, 3'(k), 2'd0, 0));
    tbl.push_back(mk(1, 8'h09, 1, 8'hEE, 0,0,0,0,0, 0,0,0,0, 3'd0, 2'd0, 0));
    tbl.push_back(mk(1, 8'h09, 1, 8'hEE, 0,0,0,0,0, 0,0,0,0, 3'd0, 2'd0, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 8'h09, 1, 8'hEE, 0,0,1,1,0, 0,0,0,0, 3'(k), 2'(k), 1));
    tbl.push_back(mk(1, 8'h09, 1, 8'hEE, 1,3'd1,1,1,0, 0,0,0,0, 3'd4, 2'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1,3'd6,0,0,0, 0,0,0,0, 3'd1, 2'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0,0,1,0,0,   0,0,0,0, 3'd6, 2'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0,0,1,1,0,   0,0,0,0, 3'd7, 2'd0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0,0,1,0,0,   0,0,0,0, 3'd7, 2'd1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1,3'd3,1,1,1, 0,0,0,0, 3'd7, 2'd1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1,3'd5,1,1,1, 1,1,0,0, 3'd0, 2'd0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0,0,0,0,0,   1,1,0,0, 3'd0, 2'd0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      s_valid_x = tbl[i].vx; s_data_in_x = tbl[i].dx;
      s_valid_f = tbl[i].vf; s_data_in_f = tbl[i].df;
      load_xaddr = tbl[i].ld; load_xaddr_val = tbl[i].lv;
      en_xaddr_incr = tbl[i].ix; en_faddr_incr = tbl[i].ifa; conv_done = tbl[i].dn;
      #1;
      chk($sformatf("row%0d s_ready_x", i), s_ready_x, tbl[i].rx);
      chk($sformatf("row%0d s_ready_f", i), s_ready_f, tbl[i].rf);
      chk($sformatf("row%0d x_wr_en", i), x_wr_en, tbl[i].wx);
      chk($sformatf("row%0d f_wr_en", i), f_wr_en, tbl[i].wf);
      chk($sformatf("row%0d x_addr", i), x_addr, tbl[i].xa);
      chk($sformatf("row%0d f_addr", i), f_addr, tbl[i].fa);
      chk($sformatf("row%0d conv_start", i), conv_start, tbl[i].cs);
      if (tbl[i].vx) chk($sformatf("row%0d x_wr_data", i), x_wr_data, tbl[i].dx);
      if (tbl[i].vf) chk($sformatf("row%0d f_wr_data", i), f_wr_data, tbl[i].df);
    end

    // gapped reload, 4th f sample held back until 10 cycles after x is full
    model_reset();
    n_xw = 0; xdone = -1; c = 0;
    while (!m_conv && c < 300) begin
      vx = (m_xcnt < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      vf = 1'($urandom_range(0, 1)) && (m_fcnt < 3 || (xdone >= 0 && c >= xdone + 10));
      cyc(1'b1, vx, 8'(8'h40 + c), vf, 8'(8'h80 + c), 1'b0);
      if (m_xf && xdone < 0) xdone = c;
      c++;
    end
    chk("gap reached conv", m_conv, 1'b1);
    chk("gap x write count", n_xw, 8);
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // mid-load reset discards three x writes
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 8'(k), 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_xw = 0;
    c = 0;
    while (!m_conv && c < 100) begin
      cyc(1'b1, (m_xcnt < 8), 8'(8'h10 + c), 1'b1, 8'(8'h20 + c), 1'b0);
      c++;
    end
    chk("reset reload conv", m_conv, 1'b1);
    chk("reset reload x writes", n_xw, 8);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
